fifo_access_arbiter: RTL and testbench

- Shares the single on-board FIFO between two requesters: port 0 is the UART command service, port 1 is a local/debug requester such as a button pattern generator.
- Accepts write, read or read+write operations and grants them round-robin.
- Drives the FIFO strobes, checks the full/empty flags, and returns read data and per-operation status to the granted requester.
- Maintains an occupancy counter for status display.

---
 rtl/fifo_arb_pkg.sv | 35 +++
 rtl/rr_arb2.sv | 44 ++++
 rtl/fifo_access_arbiter.sv | 150 +++++++++++++++
 tb/tb_fifo_access_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg
// Shared types and constants for the FIFO access arbiter.
//   state_t   : arbiter FSM states
//   op_t      : operation code {rd, wr} latched at grant
//   PORT0/1   : requester indices (0 = UART command service, 1 = local/debug)
//   NUM_PORTS : number of requesters sharing the FIFO
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_WR   = 2'b01,
    OP_RD   = 2'b10,
    OP_RW   = 2'b11
  } op_t;

  localparam int   NUM_PORTS = 2;
  localparam logic PORT0     = 1'b0;
  localparam logic PORT1     = 1'b1;

  function automatic logic op_has_wr(op_t op);
    return op[0];
  endfunction

  function automatic logic op_has_rd(op_t op);
    return op[1];
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2
// Two-requester round-robin grant with a registered last-grant pointer.
// Ports:
//   clk       : system clock
//   rst       : asynchronous active-low reset (pointer favours port 0 after reset)
//   req[1:0]  : request vector
//   en        : grant enable; the pointer only moves when en is high and someone requests
//   gnt_valid : at least one port is requesting
//   gnt_idx   : index of the port that wins this cycle
module rr_arb2
  import fifo_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  logic last;

  // A lone requester wins outright; on contention the port not granted last wins.
  always_comb begin
    gnt_valid = |req;
    gnt_idx   = PORT0;
    case (req)
      2'b01:   gnt_idx = PORT0;
      2'b10:   gnt_idx = PORT1;
      2'b11:   gnt_idx = ~last;
      default: gnt_idx = PORT0;
    endcase
  end

  // Reset the pointer as if port 1 had just been served so port 0 wins the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last <= PORT1;
    end else if (en && gnt_valid) begin
      last <= gnt_idx;
    end
  end

endmodule

// File: rtl/fifo_access_arbiter.sv
// fifo_access_arbiter
// Shares one FIFO between two requesters (port 0 UART service, port 1 local/debug).
// Each granted operation (write, read or read+write) runs IDLE -> ISSUE -> WAIT -> DONE,
// so an ack arrives 3 cycles after the request is taken and operations are 4 cycles apart.
// Ports:
//   clk, rst           : clock, asynchronous active-low reset
//   req_wr/req_rd[1:0] : per-port requests, held until ack
//   req_wdata          : per-port write data, port p at [p*DATA_W +: DATA_W]
//   ack/err[1:0]       : one-cycle completion pulse and refusal status for the granted port
//   rdata/rvalid       : shared read data, valid with ack when the read was issued
//   fifo_*             : FIFO strobes, write data, registered read data and flags
//   level              : tracked occupancy 0..DEPTH
//   busy               : high whenever an operation is in flight
module fifo_access_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int LVL_W  = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_PORTS-1:0]   req_wr,
  input  logic [NUM_PORTS-1:0]   req_rd,
  input  logic [2*DATA_W-1:0]    req_wdata,
  output logic [NUM_PORTS-1:0]   ack,
  output logic [NUM_PORTS-1:0]   err,
  output logic [DATA_W-1:0]      rdata,
  output logic                   rvalid,
  output logic                   fifo_wr_en,
  output logic [DATA_W-1:0]      fifo_wr_data,
  output logic                   fifo_rd_en,
  input  logic [DATA_W-1:0]      fifo_rd_data,
  input  logic                   fifo_full,
  input  logic                   fifo_empty,
  output logic [LVL_W-1:0]       level,
  output logic                   busy
);

  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(DEPTH);

  state_t              state;
  state_t              state_nxt;
  logic                gnt_valid;
  logic                gnt_idx;
  logic                gnt_q;
  op_t                 req_op;
  op_t                 op_q;
  logic [DATA_W-1:0]   req_data;
  logic                wr_ok;
  logic                rd_ok;

  rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req_wr | req_rd),
    .en        (state == IDLE),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // Operation and data of whichever port the arbiter currently favours.
  always_comb begin
    req_op   = op_t'({req_rd[gnt_idx], req_wr[gnt_idx]});
    req_data = gnt_idx ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
  end

  // Fixed four-step sequence; only IDLE waits on anything.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_valid) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Registered outputs and per-operation bookkeeping.
  // Strobes are computed on the edge that enters ISSUE so they are high for the whole
  // ISSUE cycle. The flags seen on that edge are the ones ISSUE sees, because the FIFO
  // only moves on our own strobes. Each part of a read+write is judged on the flags
  // alone, so a full FIFO refuses the write even though the read would free a slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack          <= '0;
      err          <= '0;
      rdata        <= '0;
      rvalid       <= 1'b0;
      fifo_wr_en   <= 1'b0;
      fifo_rd_en   <= 1'b0;
      fifo_wr_data <= '0;
      level        <= '0;
      busy         <= 1'b0;
      gnt_q        <= PORT0;
      op_q         <= OP_NONE;
      wr_ok        <= 1'b0;
      rd_ok        <= 1'b0;
    end else begin
      ack          <= '0;
      err          <= '0;
      rdata        <= '0;
      rvalid       <= 1'b0;
      fifo_wr_en   <= 1'b0;
      fifo_rd_en   <= 1'b0;
      fifo_wr_data <= '0;
      busy         <= (state_nxt != IDLE);
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            gnt_q        <= gnt_idx;
            op_q         <= req_op;
            wr_ok        <= op_has_wr(req_op) & ~fifo_full;
            rd_ok        <= op_has_rd(req_op) & ~fifo_empty;
            fifo_wr_en   <= op_has_wr(req_op) & ~fifo_full;
            fifo_rd_en   <= op_has_rd(req_op) & ~fifo_empty;
            fifo_wr_data <= req_data;
          end
        end
        ISSUE: begin
          // A simultaneous read and write leaves occupancy unchanged; clamp at both ends.
          if (fifo_wr_en && !fifo_rd_en && level != LVL_MAX) begin
            level <= level + LVL_W'(1);
          end else if (fifo_rd_en && !fifo_wr_en && level != '0) begin
            level <= level - LVL_W'(1);
          end
        end
        WAIT: begin
          // The FIFO presents read data during WAIT; capture it for the DONE cycle.
          ack[gnt_q] <= 1'b1;
          err[gnt_q] <= (op_has_wr(op_q) & ~wr_ok) | (op_has_rd(op_q) & ~rd_ok);
          rvalid     <= rd_ok;
          rdata      <= rd_ok ? fifo_rd_data : '0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_access_arbiter.sv
// tb_fifo_access_arbiter
// Drives both requesters, emulates the FIFO with a queue, predicts every operation's
// response from the arbitration and occupancy rules, and compares in a separate monitor.
module tb_fifo_access_arbiter;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int LVL_W  = $clog2(DEPTH + 1);
  localparam logic [1:0] WR = 2'b01;
  localparam logic [1:0] RD = 2'b10;
  localparam logic [1:0] RW = 2'b11;

  logic                clk;
  logic                rst;
  logic [1:0]          req_wr;
  logic [1:0]          req_rd;
  logic [2*DATA_W-1:0] req_wdata;
  logic [1:0]          ack;
  logic [1:0]          err;
  logic [DATA_W-1:0]   rdata;
  logic                rvalid;
  logic                fifo_wr_en;
  logic [DATA_W-1:0]   fifo_wr_data;
  logic                fifo_rd_en;
  logic [DATA_W-1:0]   fifo_rd_data;
  logic                fifo_full;
  logic                fifo_empty;
  logic [LVL_W-1:0]    level;
  logic                busy;

  typedef struct {
    logic [1:0] ack;
    logic [1:0] err;
    logic       rvalid;
    logic [7:0] rdata;
    int         level;
    int         wr_iss;
    int         rd_iss;
    logic [7:0] wdata;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] ref_q[$];
  logic [7:0] mem[$];

  int         vectors     = 0;
  int         miscompares = 0;
  logic [1:0] pend        = 2'b00;
  logic [1:0] pend_op[2];
  logic [7:0] pend_data[2];
  logic       last_grant  = 1'b1;
  bit         abort       = 1'b0;

  fifo_access_arbiter #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_wr       (req_wr),
    .req_rd       (req_rd),
    .req_wdata    (req_wdata),
    .ack          (ack),
    .err          (err),
    .rdata        (rdata),
    .rvalid       (rvalid),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .level        (level),
    .busy         (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_ack"},       32'(ack), 0);
    checkOutput({tag, "_err"},       32'(err), 0);
    checkOutput({tag, "_rdata"},     32'(rdata), 0);
    checkOutput({tag, "_rvalid"},    32'(rvalid), 0);
    checkOutput({tag, "_wr_en"},     32'(fifo_wr_en), 0);
    checkOutput({tag, "_rd_en"},     32'(fifo_rd_en), 0);
    checkOutput({tag, "_wr_data"},   32'(fifo_wr_data), 0);
    checkOutput({tag, "_level"},     32'(level), 0);
    checkOutput({tag, "_busy"},      32'(busy), 0);
  endtask

  // FIFO emulation: strobes observed mid-cycle, read data and flags updated right away.
  initial begin
    fifo_full    = 1'b0;
    fifo_empty   = 1'b1;
    fifo_rd_data = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        mem.delete();
        fifo_rd_data = '0;
      end else begin
        if (fifo_rd_en && mem.size() > 0) fifo_rd_data = mem.pop_front();
        if (fifo_wr_en && mem.size() < DEPTH) mem.push_back(fifo_wr_data);
      end
      fifo_full  = (mem.size() == DEPTH);
      fifo_empty = (mem.size() == 0);
    end
  end

  // Monitor: checks write data on each strobe and every completion against the queue.
  initial begin
    int   cyc        = 0;
    int   wr_cnt     = 0;
    int   rd_cnt     = 0;
    int   strobe_cyc = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        wr_cnt = 0;
        rd_cnt = 0;
      end else begin
        if (fifo_wr_en) begin
          wr_cnt++;
          strobe_cyc = cyc;
          if (exp_q.size() > 0) checkOutput("wr_data", 32'(fifo_wr_data), 32'(exp_q[0].wdata));
        end
        if (fifo_rd_en) begin
          rd_cnt++;
          strobe_cyc = cyc;
        end
        if (ack !== 2'b00) begin
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_ack", 32'(ack), 0);
          end else begin
            e = exp_q.pop_front();
            checkOutput("ack",       32'(ack), 32'(e.ack));
            checkOutput("err",       32'(err), 32'(e.err));
            checkOutput("rvalid",    32'(rvalid), 32'(e.rvalid));
            checkOutput("rdata",     32'(rdata), 32'(e.rdata));
            checkOutput("level",     32'(level), e.level);
            checkOutput("busy",      32'(busy), 1);
            checkOutput("wr_strobes", wr_cnt, e.wr_iss);
            checkOutput("rd_strobes", rd_cnt, e.rd_iss);
            checkOutput("wr_data_idle", 32'(fifo_wr_data), 0);
            if (wr_cnt + rd_cnt > 0) checkOutput("ack_latency", cyc - strobe_cyc, 2);
          end
          wr_cnt = 0;
          rd_cnt = 0;
        end
      end
    end
  end

  // Raise (or replace) port p's request; held until its ack is seen.
  task automatic applyStimulus(input int p, input logic [1:0] op, input logic [7:0] data);
    req_wr[p]               = op[0];
    req_rd[p]               = op[1];
    req_wdata[p*DATA_W +: DATA_W] = data;
    pend[p]                 = 1'b1;
    pend_op[p]              = op;
    pend_data[p]            = data;
  endtask

  // Predict the next grant and its outcome, queue it, then wait for that port's ack.
  task automatic serveOne();
    logic       g;
    logic [1:0] op;
    bit         wr_ok;
    bit         rd_ok;
    bit         seen;
    exp_t       e;
    if (abort) return;
    if (pend == 2'b11) g = ~last_grant;
    else               g = pend[1];
    last_grant = g;
    op    = pend_op[g];
    wr_ok = op[0] && (ref_q.size() < DEPTH);
    rd_ok = op[1] && (ref_q.size() > 0);
    e.ack    = (g == 1'b1) ? 2'b10 : 2'b01;
    e.err    = ((op[0] && !wr_ok) || (op[1] && !rd_ok)) ? e.ack : 2'b00;
    e.rvalid = rd_ok;
    e.rdata  = rd_ok ? ref_q[0] : 8'h00;
    e.wr_iss = wr_ok ? 1 : 0;
    e.rd_iss = rd_ok ? 1 : 0;
    e.wdata  = pend_data[g];
    if (rd_ok) void'(ref_q.pop_front());
    if (wr_ok) ref_q.push_back(pend_data[g]);
    e.level = ref_q.size();
    exp_q.push_back(e);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ack[g] === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL ack_timeout: port %0d got no ack, expected ack within 12 cycles", g);
      abort = 1'b1;
    end
    pend[g]   = 1'b0;
    req_wr[g] = 1'b0;
    req_rd[g] = 1'b0;
  endtask

  function automatic logic [1:0] randOp(input int phase);
    int r;
    r = $urandom_range(0, 99);
    case (phase)
      0:       return (r < 60) ? WR : ((r < 80) ? RD : RW);
      1:       return (r < 60) ? RD : ((r < 80) ? WR : RW);
      default: return (r < 33) ? WR : ((r < 66) ? RD : RW);
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst       = 1'b0;
    req_wr    = 2'b00;
    req_rd    = 2'b00;
    req_wdata = '0;
    #12;
    checkResetState("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Simultaneous writes after reset: port 0 first; port 0 re-requests at once so port 1 goes next.
    applyStimulus(0, WR, 8'hA5);
    applyStimulus(1, WR, 8'h3C);
    serveOne();
    applyStimulus(0, WR, 8'h77);
    serveOne();
    serveOne();

    // Drain, then an empty read and a read+write on an empty FIFO.
    applyStimulus(1, RD, 8'h00); serveOne();
    applyStimulus(1, RD, 8'h00); serveOne();
    applyStimulus(0, RD, 8'h00); serveOne();
    applyStimulus(1, RD, 8'h00); serveOne();
    applyStimulus(0, RW, 8'h5A); serveOne();
    applyStimulus(1, RD, 8'h00); serveOne();

    // Fill to DEPTH, then write into full and read+write on full.
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(i % 2, WR, 8'(8'h10 + i));
      serveOne();
    end
    applyStimulus(1, WR, 8'hEE); serveOne();
    applyStimulus(0, RW, 8'h99); serveOne();
    applyStimulus(1, RW, 8'h44); serveOne();
    applyStimulus(0, RD, 8'h00); serveOne();

    // Reset while port 1's read is in WAIT; afterwards port 0 must win the tie.
    if (!abort) begin
      applyStimulus(0, WR, 8'h12);
      applyStimulus(1, RD, 8'h00);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      checkResetState("midop_reset");
      ref_q.delete();
      last_grant = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      serveOne();
      serveOne();
    end

    // Randomized traffic: write-heavy, read-heavy, then mixed.
    for (int n = 0; n < 260 && !abort; n++) begin
      int phase;
      phase = (n < 80) ? 0 : ((n < 180) ? 1 : 2);
      if (pend == 2'b00) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 99) < 60) applyStimulus(p, randOp(phase), 8'($urandom));
      end
      if (pend == 2'b00) applyStimulus($urandom_range(0, 1), randOp(phase), 8'($urandom));
      serveOne();
    end

    repeat (3) @(negedge clk);
    checkOutput("pending_expects", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
